// File: rtl/hrd_board_scan.sv
// hrd_board_scan: VGA scan -> Klotski board cell lookup with frame-synchronous shadow board commit
// Optional cursor frame output is enabled by defining HRD_HILITE_EN.
module hrd_board_scan #(
  parameter int X0 = 192,
  parameter int Y0 = 80,
  parameter int CELL_LG2 = 6,
  parameter logic SYNC_ACT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic [9:0] col,
  input  logic [8:0] row,
  input  logic de_in,
  input  logic hs_in,
  input  logic vs_in,
  output logic [4:0] sel,
  output logic [CELL_LG2-1:0] u_off,
  output logic [CELL_LG2-1:0] v_off,
  output logic de_o,
  output logic hs_o,
  output logic vs_o,
  input  logic upd_valid,
  output logic upd_ready,
  input  logic [4:0] upd_cell,
  input  logic [4:0] upd_id,
  input  logic upd_commit,
  output logic commit_pend,
  output logic commit_done,
`ifdef HRD_HILITE_EN
  input  logic [4:0] cur_cell,
  input  logic cur_en,
  output logic hilite,
`endif
  output logic upd_err
);
  logic [4:0] active [20];
  logic [4:0] shadow [20];
  logic [9:0] dx, dxc;
  logic [8:0] dy, dyc;
  logic in_c;
  logic [4:0] cell_c;
  logic in1, de1, hs1, vs1;
  logic [4:0] cell1;
  logic [CELL_LG2-1:0] u1, v1;
  logic vs_d, vs_fs;
  always_comb begin
    dx = col - 10'(X0);
    dy = row - 9'(Y0);
    dxc = dx >> CELL_LG2;
    dyc = dy >> CELL_LG2;
    in_c = de_in && col >= 10'(X0) && dx < 10'(4 << CELL_LG2) && row >= 9'(Y0) && dy < 9'(5 << CELL_LG2);
    cell_c = 5'({dyc, 2'b00} + {1'b0, dxc});
  end
`ifdef HRD_HILITE_EN
  logic hl1;
  logic hl_c;
  always_comb hl_c = in_c && cell_c == cur_cell && cur_en &&
    (dx[CELL_LG2-1:0] == '0 || &dx[CELL_LG2-1:0] || dy[CELL_LG2-1:0] == '0 || &dy[CELL_LG2-1:0]);
  always_ff @(posedge clk)
    if (rst) begin
      hl1 <= 1'b0;
      hilite <= 1'b0;
    end else begin
      hl1 <= hl_c;
      hilite <= hl1;
    end
`endif
  always_ff @(posedge clk)
    if (rst) begin
      {in1, de1, de_o} <= '0;
      {hs1, vs1, hs_o, vs_o} <= {4{~SYNC_ACT}};
      cell1 <= '0;
      {u1, v1, u_off, v_off} <= '0;
      sel <= '0;
    end else begin
      in1 <= in_c;
      cell1 <= cell_c;
      u1 <= dx[CELL_LG2-1:0];
      v1 <= dy[CELL_LG2-1:0];
      {de1, hs1, vs1} <= {de_in, hs_in, vs_in};
      sel <= in1 ? active[cell1] : 5'd0;
      u_off <= in1 ? u1 : '0;
      v_off <= in1 ? v1 : '0;
      {de_o, hs_o, vs_o} <= {de1, hs1, vs1};
    end
  // copy and write are mutually exclusive because ready drops during the copy cycle
  always_comb commit_done = vs_fs && commit_pend;
  always_comb upd_ready = !commit_done;
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 20; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
      vs_d <= ~SYNC_ACT;
      vs_fs <= 1'b0;
      commit_pend <= 1'b0;
      upd_err <= 1'b0;
    end else begin
      vs_d <= vs_in;
      vs_fs <= vs_in == SYNC_ACT && vs_d != SYNC_ACT;
      commit_pend <= commit_done ? upd_commit : commit_pend | upd_commit;
      if (commit_done)
        for (int i = 0; i < 20; i++) active[i] <= shadow[i];
      if (upd_valid && upd_ready) begin
        if (upd_cell < 5'd20 && upd_id < 5'd19) shadow[upd_cell] <= upd_id;
        else upd_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_hrd_board_scan.sv
// tb_hrd_board_scan: directed vector table plus hand-written commit/handshake sequences
module tb_hrd_board_scan;
  localparam int X0 = 192, Y0 = 80;
  logic clk = 0, rst = 1;
  logic [9:0] col = 0;
  logic [8:0] row = 0;
  logic de_in = 0, hs_in = 1, vs_in = 1;
  logic [4:0] sel;
  logic [5:0] u_off, v_off;
  logic de_o, hs_o, vs_o;
  logic upd_valid = 0, upd_ready, upd_commit = 0;
  logic [4:0] upd_cell = 0, upd_id = 0;
  logic commit_pend, commit_done, upd_err;
`ifdef HRD_HILITE_EN
  logic [4:0] cur_cell = 0;
  logic cur_en = 0;
  logic hilite;
`endif
  int checks = 0, errors = 0;

  hrd_board_scan dut (
    .clk(clk), .rst(rst), .col(col), .row(row), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .sel(sel), .u_off(u_off), .v_off(v_off), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_cell(upd_cell), .upd_id(upd_id),
    .upd_commit(upd_commit), .commit_pend(commit_pend), .commit_done(commit_done),
`ifdef HRD_HILITE_EN
    .cur_cell(cur_cell), .cur_en(cur_en), .hilite(hilite),
`endif
    .upd_err(upd_err));

  always #5 clk = ~clk;

  typedef struct {
    int c; int r; logic d; logic h;
    int e_sel; int e_u; int e_v; logic e_de; logic e_hs;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pix(input int c, input int r, input logic d, input logic h);
    @(negedge clk);
    col = 10'(c);
    row = 9'(r);
    de_in = d;
    hs_in = h;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input int id);
    bit done = 0;
    @(negedge clk);
    upd_valid = 1;
    upd_cell = 5'(c);
    upd_id = 5'(id);
    for (int k = 0; k < 10 && !done; k++) begin
      done = upd_ready;
      @(posedge clk);
    end
    if (!done) chk("wr_timeout", 0, 1);
    @(negedge clk);
    upd_valid = 0;
  endtask

  task automatic commit_req();
    @(negedge clk);
    upd_commit = 1;
    @(negedge clk);
    upd_commit = 0;
  endtask

  task automatic frame(input string tag);
    @(negedge clk);
    vs_in = 0;
    @(negedge clk);
    chk({tag, "_done"}, int'(commit_done), 1);
    chk({tag, "_rdy_low"}, int'(upd_ready), 0);
    @(negedge clk);
    vs_in = 1;
    chk({tag, "_done_clr"}, int'(commit_done), 0);
    chk({tag, "_pend_clr"}, int'(commit_pend), 0);
  endtask

  vec_t vt [10];

  initial begin
    int bad;
    vt[0] = '{X0+64,  Y0+64,  1, 1, 3, 0,  0,  1, 1};
    vt[1] = '{X0+127, Y0+127, 1, 1, 3, 63, 63, 1, 1};
    vt[2] = '{X0-1,   Y0+64,  1, 1, 0, 0,  0,  1, 1};
    vt[3] = '{X0+256, Y0+64,  1, 1, 0, 0,  0,  1, 1};
    vt[4] = '{X0+255, Y0+319, 1, 1, 7, 63, 63, 1, 1};
    vt[5] = '{X0,     Y0,     1, 1, 0, 0,  0,  1, 1};
    vt[6] = '{X0+64,  Y0+64,  0, 1, 0, 0,  0,  0, 1};
    vt[7] = '{X0+64,  Y0+320, 1, 1, 0, 0,  0,  1, 1};
    vt[8] = '{X0+100, Y0+70,  1, 0, 3, 36, 6,  1, 0};
    vt[9] = '{X0+200, Y0-1,   1, 1, 0, 0,  0,  1, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_sel", int'(sel), 0);
    chk("rst_u", int'(u_off), 0);
    chk("rst_v", int'(v_off), 0);
    chk("rst_de", int'(de_o), 0);
    chk("rst_hs", int'(hs_o), 1);
    chk("rst_vs", int'(vs_o), 1);
    chk("rst_pend", int'(commit_pend), 0);
    chk("rst_done", int'(commit_done), 0);
    chk("rst_err", int'(upd_err), 0);
    chk("rst_ready", int'(upd_ready), 1);

    bad = 0;
    for (int r = 0; r < 480; r += 16)
      for (int c = 0; c < 640; c += 8) begin
        @(negedge clk);
        col = 10'(c);
        row = 9'(r);
        de_in = 1;
        if (sel != 0) bad++;
      end
    chk("scan_zero", bad, 0);

    wr(5, 3);
    wr(19, 7);
    commit_req();
    chk("pend_set", int'(commit_pend), 1);
    pix(X0+64, Y0+64, 1, 1);
    chk("pre_vs_sel", int'(sel), 0);
    frame("c1");

    foreach (vt[i]) begin
      pix(vt[i].c, vt[i].r, vt[i].d, vt[i].h);
      chk($sformatf("vec%0d_sel", i), int'(sel), vt[i].e_sel);
      chk($sformatf("vec%0d_u", i), int'(u_off), vt[i].e_u);
      chk($sformatf("vec%0d_v", i), int'(v_off), vt[i].e_v);
      chk($sformatf("vec%0d_de", i), int'(de_o), int'(vt[i].e_de));
      chk($sformatf("vec%0d_hs", i), int'(hs_o), int'(vt[i].e_hs));
    end

    // write held across the copy cycle, plus a re-commit in that same cycle
    commit_req();
    @(negedge clk);
    vs_in = 0;
    @(negedge clk);
    upd_valid = 1;
    upd_cell = 5'd1;
    upd_id = 5'd11;
    upd_commit = 1;
    chk("hold_rdy_low", int'(upd_ready), 0);
    chk("hold_done", int'(commit_done), 1);
    @(negedge clk);
    upd_commit = 0;
    chk("hold_rdy_high", int'(upd_ready), 1);
    chk("hold_pend_kept", int'(commit_pend), 1);
    @(negedge clk);
    upd_valid = 0;
    vs_in = 1;
    pix(X0+64, Y0, 1, 1);
    chk("shadow_only_sel", int'(sel), 0);
    frame("c2");
    pix(X0+64, Y0+10, 1, 1);
    chk("late_write_sel", int'(sel), 11);
    chk("late_write_v", int'(v_off), 10);

    wr(20, 4);
    chk("err_cell", int'(upd_err), 1);
    wr(3, 19);
    chk("err_sticky", int'(upd_err), 1);
    commit_req();
    frame("c3");
    pix(X0+192, Y0, 1, 1);
    chk("illegal_unchanged", int'(sel), 0);
    pix(X0+64, Y0+64, 1, 1);
    chk("cell5_kept", int'(sel), 3);

`ifdef HRD_HILITE_EN
    cur_en = 1;
    cur_cell = 0;
    pix(X0, Y0, 1, 1);
    chk("hl_corner", int'(hilite), 1);
    pix(X0+63, Y0+10, 1, 1);
    chk("hl_edge", int'(hilite), 1);
    pix(X0+10, Y0+10, 1, 1);
    chk("hl_inner", int'(hilite), 0);
    cur_en = 0;
`endif

    commit_req();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst2_err", int'(upd_err), 0);
    chk("rst2_pend", int'(commit_pend), 0);
    pix(X0+64, Y0+64, 1, 1);
    chk("rst2_board", int'(sel), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
